// File: rtl/cr16_ctrl_pkg.sv
// Shared encodings for the CR16 multicycle control unit: FSM states, opcode/ext
// fields, PSR bit positions, branch condition codes and result-mux selects.
package cr16_ctrl_pkg;

    localparam int WIDTH   = 16;
    localparam int REGBITS = 4;
    localparam int PSRBITS = 8;

    typedef enum logic [3:0] {
        S_FETCH,
        S_FETCH2,
        S_DECODE,
        S_EX_ALU,
        S_EX_SHIFT,
        S_WB,
        S_LD_RD,
        S_LD_WB,
        S_ST,
        S_BRANCH,
        S_JUMP,
        S_JAL,
        S_JAL_WB,
        S_PC_INC
    } state_e;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_MEM   = 4'b0100;
    localparam logic [3:0] OP_SHIFT = 4'b1000;
    localparam logic [3:0] OP_BCOND = 4'b1100;

    localparam logic [3:0] EXT_LOAD      = 4'b0000;
    localparam logic [3:0] EXT_STOR      = 4'b0100;
    localparam logic [3:0] EXT_JAL       = 4'b1000;
    localparam logic [3:0] EXT_JCOND     = 4'b1100;
    localparam logic [3:0] EXT_SHIFT_REG = 4'b0100;

    localparam logic [3:0] ALU_ADD = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b1001;
    localparam logic [3:0] ALU_CMP = 4'b1011;

    localparam int PSR_C = 0;
    localparam int PSR_L = 2;
    localparam int PSR_F = 5;
    localparam int PSR_Z = 6;
    localparam int PSR_N = 7;

    typedef enum logic [3:0] {
        C_EQ, C_NE, C_CS, C_CC, C_HI, C_LS, C_GT, C_LE,
        C_FS, C_FC, C_LO, C_HS, C_LT, C_GE, C_UC, C_NV
    } cond_e;

    localparam logic [1:0] RES_SHIFT = 2'b00;
    localparam logic [1:0] RES_ALU   = 2'b01;
    localparam logic [1:0] RES_PCALU = 2'b10;
    localparam logic [1:0] RES_LINK  = 2'b11;

    function automatic logic is_imm_alu(input logic [3:0] op);
        return op inside {4'b0001, 4'b0010, 4'b0011, 4'b0101, 4'b1001, 4'b1011, 4'b1101};
    endfunction

    function automatic logic is_zero_ext(input logic [3:0] op);
        return op inside {4'b0001, 4'b0010, 4'b0011};
    endfunction

    function automatic logic is_psr_op(input logic [3:0] alu_code);
        return alu_code inside {ALU_ADD, ALU_SUB, ALU_CMP};
    endfunction

endpackage

// File: rtl/cr16_cond_eval.sv
// Combinational branch/jump condition evaluator: maps a 4-bit condition code and
// the PSR flags to a single take decision.
module cr16_cond_eval
    import cr16_ctrl_pkg::*;
(
    input  logic [3:0]         cond_i,
    input  logic [PSRBITS-1:0] psr_i,
    output logic               take_o
);

    logic z, n, c, l, f;
    logic [2:0] unused_psr;

    assign z = psr_i[PSR_Z];
    assign n = psr_i[PSR_N];
    assign c = psr_i[PSR_C];
    assign l = psr_i[PSR_L];
    assign f = psr_i[PSR_F];
    assign unused_psr = {psr_i[4:3], psr_i[1]};

    always_comb begin
        take_o = 1'b0;
        case (cond_e'(cond_i))
            C_EQ: take_o = z;
            C_NE: take_o = !z;
            C_CS: take_o = c;
            C_CC: take_o = !c;
            C_HI: take_o = l;
            C_LS: take_o = !l;
            C_GT: take_o = n;
            C_LE: take_o = !n;
            C_FS: take_o = f;
            C_FC: take_o = !f;
            C_LO: take_o = !l && !z;
            C_HS: take_o = l || z;
            C_LT: take_o = !n && !z;
            C_GE: take_o = n || z;
            C_UC: take_o = 1'b1;
            C_NV: take_o = 1'b0;
            default: take_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/cr16_control_fsm.sv
// Moore multicycle control FSM for the CR16 datapath: sequences fetch, decode,
// execute, memory and writeback, and drives every datapath strobe and select.
module cr16_control_fsm
    import cr16_ctrl_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int REGBITS = 4,
    parameter int PSRBITS = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   instr,
    input  logic [PSRBITS-1:0] psr,
    input  logic               stall,
    output logic               PCEN,
    output logic               PSREN,
    output logic               nextInstruction,
    output logic               regWrite,
    output logic               resultEn,
    output logic               memWrite,
    output logic               updateAddress,
    output logic               StoreReg,
    output logic               WriteData,
    output logic               ZeroExtend,
    output logic               PCinstruction,
    output logic               SrcB,
    output logic               shiftType,
    output logic               jumpEN,
    output logic               BranchEN,
    output logic               jalEN,
    output logic [REGBITS-1:0] ALUcond,
    output logic [1:0]         chooseResult,
    output logic               illegal
);

    state_e     state_q, state_d;
    state_e     exec_state;
    logic       take_q, take;
    logic       illegal_q;
    logic       decode_illegal;
    logic [3:0] op, rd, ext, alu_code;
    logic [3:0] unused_rs;

    assign op        = instr[15:12];
    assign rd        = instr[11:8];
    assign ext       = instr[7:4];
    assign unused_rs = instr[3:0];
    assign alu_code  = (op == OP_RTYPE) ? ext : op;
    assign illegal   = illegal_q;

    cr16_cond_eval u_cond_eval (
        .cond_i (rd),
        .psr_i  (psr),
        .take_o (take)
    );

    // Execute-state selection from the latched instruction; undefined encodings fall to PC_INC.
    always_comb begin
        exec_state     = S_PC_INC;
        decode_illegal = 1'b0;
        case (op)
            OP_RTYPE: exec_state = S_EX_ALU;
            OP_MEM: begin
                case (ext)
                    EXT_LOAD:  exec_state = S_LD_RD;
                    EXT_STOR:  exec_state = S_ST;
                    EXT_JAL:   exec_state = S_JAL;
                    EXT_JCOND: exec_state = S_JUMP;
                    default:   decode_illegal = 1'b1;
                endcase
            end
            OP_SHIFT: begin
                if (ext == EXT_SHIFT_REG || ext[3:1] == 3'b000) exec_state = S_EX_SHIFT;
                else decode_illegal = 1'b1;
            end
            OP_BCOND: exec_state = S_BRANCH;
            default: begin
                if (is_imm_alu(op)) exec_state = S_EX_ALU;
                else decode_illegal = 1'b1;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            take_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else if (!stall) begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                take_q <= take;
                if (decode_illegal) illegal_q <= 1'b1;
            end
        end
    end

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d         = state_q;
        PCEN            = 1'b0;
        PSREN           = 1'b0;
        nextInstruction = 1'b0;
        regWrite        = 1'b0;
        resultEn        = 1'b0;
        memWrite        = 1'b0;
        updateAddress   = 1'b0;
        StoreReg        = 1'b0;
        WriteData       = 1'b0;
        ZeroExtend      = 1'b0;
        PCinstruction   = 1'b0;
        SrcB            = 1'b0;
        shiftType       = 1'b0;
        jumpEN          = 1'b0;
        BranchEN        = 1'b0;
        jalEN           = 1'b0;
        ALUcond         = '0;
        chooseResult    = RES_SHIFT;

        case (state_q)
            S_FETCH: begin
                updateAddress = 1'b1;
                state_d       = S_FETCH2;
            end
            S_FETCH2: begin
                updateAddress   = 1'b1;
                nextInstruction = 1'b1;
                state_d         = S_DECODE;
            end
            S_DECODE: state_d = exec_state;
            S_EX_ALU: begin
                resultEn     = 1'b1;
                chooseResult = RES_ALU;
                ALUcond      = alu_code;
                SrcB         = (op == OP_RTYPE);
                ZeroExtend   = is_zero_ext(op);
                PSREN        = is_psr_op(alu_code);
                state_d      = (alu_code == ALU_CMP) ? S_PC_INC : S_WB;
            end
            S_EX_SHIFT: begin
                resultEn     = 1'b1;
                chooseResult = RES_SHIFT;
                SrcB         = (ext == EXT_SHIFT_REG);
                shiftType    = (ext != EXT_SHIFT_REG) && ext[0];
                state_d      = S_WB;
            end
            S_WB: begin
                regWrite  = 1'b1;
                WriteData = 1'b1;
                state_d   = S_PC_INC;
            end
            S_LD_RD: state_d = S_LD_WB;
            S_LD_WB: begin
                regWrite = 1'b1;
                state_d  = S_PC_INC;
            end
            S_ST: begin
                StoreReg = 1'b1;
                memWrite = 1'b1;
                state_d  = S_PC_INC;
            end
            S_BRANCH: begin
                if (take_q) begin
                    PCEN          = 1'b1;
                    BranchEN      = 1'b1;
                    PCinstruction = 1'b1;
                    state_d       = S_FETCH;
                end else begin
                    state_d = S_PC_INC;
                end
            end
            S_JUMP: begin
                if (take_q) begin
                    PCEN    = 1'b1;
                    jumpEN  = 1'b1;
                    SrcB    = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_PC_INC;
                end
            end
            S_JAL: begin
                jalEN        = 1'b1;
                chooseResult = RES_LINK;
                resultEn     = 1'b1;
                state_d      = S_JAL_WB;
            end
            S_JAL_WB: begin
                regWrite  = 1'b1;
                WriteData = 1'b1;
                PCEN      = 1'b1;
                jalEN     = 1'b1;
                SrcB      = 1'b1;
                state_d   = S_FETCH;
            end
            S_PC_INC: begin
                PCEN    = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        // A stall freezes the state and suppresses every write, while selects keep their values.
        if (stall) begin
            state_d         = state_q;
            PCEN            = 1'b0;
            PSREN           = 1'b0;
            regWrite        = 1'b0;
            memWrite        = 1'b0;
            resultEn        = 1'b0;
            nextInstruction = 1'b0;
        end
    end

endmodule
